mem_stage: RTL and testbench

Memory-access stage of the 16-bit encryptor pipeline. Consumes the EX/MEM pipeline register outputs: control code, ALU result as effective address or pass-through value, and store data. Runs a request/acknowledge transaction with the data memory for loads and stores, and presents a one-cycle write-back pulse toward MEM/WB. Stalls the upstream pipe through `ready_o` while a memory transaction is outstanding, and aborts transactions that exceed a fixed timeout.

---
 rtl/mem_stage.sv | 133 +++++++++++++
 tb/tb_mem_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: drives a req/ack data-memory transaction for loads
// and stores, and emits a one-cycle write-back pulse toward MEM/WB.
module mem_stage #(
    parameter int D       = 16,
    parameter int TIMEOUT = 15
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic [2:0]   control_i,
    input  logic [D-1:0] alu_res_i,
    input  logic [D-1:0] rt_i,
    output logic         ready_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [D-1:0] mem_addr_o,
    output logic [D-1:0] mem_wdata_o,
    input  logic         mem_ack_i,
    input  logic [D-1:0] mem_rdata_i,
    output logic         wb_valid_o,
    output logic [D-1:0] wb_data_o,
    output logic         err_o
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          req_d;
    logic          we_d;
    logic [D-1:0]  addr_d;
    logic [D-1:0]  wdata_d;
    logic          wb_valid_d;
    logic [D-1:0]  wb_data_d;
    logic          err_d;

    logic accept;
    logic is_load;
    logic is_store;
    logic is_mem;

    assign ready_o  = (state_q == IDLE);
    assign accept   = valid_i & ready_o;
    assign is_load  = (control_i == 3'd1);
    assign is_store = (control_i == 3'd2);
    assign is_mem   = is_load | is_store;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = mem_req_o;
        we_d       = mem_we_o;
        addr_d     = mem_addr_o;
        wdata_d    = mem_wdata_o;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_o;
        err_d      = err_o;
        unique case (state_q)
            IDLE: begin
                if (accept && is_mem) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = alu_res_i;
                    wdata_d = rt_i;
                    cnt_d   = '0;
                end else if (accept) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_res_i;
                end
            end
            BUSY: begin
                // ack beats a timeout landing in the same cycle
                if (mem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    if (!mem_we_o) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            wb_valid_o  <= 1'b0;
            wb_data_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_req_o   <= req_d;
            mem_we_o    <= we_d;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
            wb_valid_o  <= wb_valid_d;
            wb_data_o   <= wb_data_d;
            err_o       <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: pass, load, store, timeout and
// reset-abort scenarios with hand-computed expectations.
module tb_mem_stage;

    localparam int D = 16;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic [2:0]   control_i;
    logic [D-1:0] alu_res_i;
    logic [D-1:0] rt_i;
    logic         ready_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [D-1:0] mem_addr_o;
    logic [D-1:0] mem_wdata_o;
    logic         mem_ack_i;
    logic [D-1:0] mem_rdata_i;
    logic         wb_valid_o;
    logic [D-1:0] wb_data_o;
    logic         err_o;

    int tests = 0;
    int fails = 0;

    mem_stage #(.D(D), .TIMEOUT(15)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .control_i  (control_i),
        .alu_res_i  (alu_res_i),
        .rt_i       (rt_i),
        .ready_o    (ready_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .wb_valid_o (wb_valid_o),
        .wb_data_o  (wb_data_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    // advance to the next cycle; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        valid_i = 1'b0;
        control_i = 3'd0;
        alu_res_i = '0;
        rt_i = '0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        repeat (5) tick();
        tests++;
        if ({ready_o, mem_req_o, mem_we_o, wb_valid_o, err_o} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_flags got %b want 10000",
                     {ready_o, mem_req_o, mem_we_o, wb_valid_o, err_o});
        end
        tests++;
        if ({mem_addr_o, mem_wdata_o, wb_data_o} !== 48'h0) begin
            fails++;
            $display("FAIL reset_data got %h want 0",
                     {mem_addr_o, mem_wdata_o, wb_data_o});
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_pass();
        tests++;
        if (ready_o !== 1'b1) begin
            fails++;
            $display("FAIL pass_ready0 got %b want 1", ready_o);
        end
        valid_i = 1'b1;
        control_i = 3'd0;
        alu_res_i = 16'd8;
        tick();
        valid_i = 1'b0;
        tests++;
        if ({wb_valid_o, wb_data_o, mem_req_o, ready_o} !== {1'b1, 16'd8, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL pass_wb got v=%b d=%h req=%b rdy=%b want v=1 d=0008 req=0 rdy=1",
                     wb_valid_o, wb_data_o, mem_req_o, ready_o);
        end
        tick();
        tests++;
        if ({wb_valid_o, wb_data_o, mem_req_o} !== {1'b0, 16'd8, 1'b0}) begin
            fails++;
            $display("FAIL pass_hold got v=%b d=%h req=%b want v=0 d=0008 req=0",
                     wb_valid_o, wb_data_o, mem_req_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops  [3] = '{3'd0, 3'd5, 3'd7};
        logic [D-1:0] vals [3] = '{16'h0011, 16'h0022, 16'h0033};
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            control_i = ops[i];
            alu_res_i = vals[i];
            tick();
            tests++;
            if ({wb_valid_o, wb_data_o, ready_o, mem_req_o} !== {1'b1, vals[i], 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL b2b_%0d got v=%b d=%h rdy=%b req=%b want v=1 d=%h rdy=1 req=0",
                         i, wb_valid_o, wb_data_o, ready_o, mem_req_o, vals[i]);
            end
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_load();
        int req_cycles = 0;
        valid_i = 1'b1;
        control_i = 3'd1;
        alu_res_i = 16'h0003;
        rt_i = 16'h9999;
        tick();
        valid_i = 1'b0;
        alu_res_i = 16'hFFFF;
        for (int c = 1; c <= 3; c++) begin
            if (mem_req_o) req_cycles++;
            tests++;
            if ({mem_req_o, mem_we_o, mem_addr_o, ready_o, wb_valid_o} !==
                {1'b1, 1'b0, 16'h0003, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL load_busy_c%0d got req=%b we=%b a=%h rdy=%b wb=%b want 1 0 0003 0 0",
                         c, mem_req_o, mem_we_o, mem_addr_o, ready_o, wb_valid_o);
            end
            if (c == 3) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 16'h00A5;
            end
            tick();
        end
        mem_ack_i = 1'b0;
        mem_rdata_i = 16'h0000;
        tests++;
        if ({mem_req_o, wb_valid_o, wb_data_o, ready_o} !== {1'b0, 1'b1, 16'h00A5, 1'b1}) begin
            fails++;
            $display("FAIL load_done got req=%b wb=%b d=%h rdy=%b want 0 1 00a5 1",
                     mem_req_o, wb_valid_o, wb_data_o, ready_o);
        end
        tests++;
        if (req_cycles != 3) begin
            fails++;
            $display("FAIL load_req_len got %0d want 3", req_cycles);
        end
        tick();
        tests++;
        if ({wb_valid_o, wb_data_o} !== {1'b0, 16'h00A5}) begin
            fails++;
            $display("FAIL load_single_pulse got wb=%b d=%h want 0 00a5", wb_valid_o, wb_data_o);
        end
    endtask

    task automatic test_store();
        valid_i = 1'b1;
        control_i = 3'd2;
        alu_res_i = 16'h0005;
        rt_i = 16'h1234;
        tick();
        valid_i = 1'b0;
        tests++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ready_o} !==
            {1'b1, 1'b1, 16'h0005, 16'h1234, 1'b0}) begin
            fails++;
            $display("FAIL store_req got req=%b we=%b a=%h wd=%h rdy=%b want 1 1 0005 1234 0",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ready_o);
        end
        mem_ack_i = 1'b1;
        mem_rdata_i = 16'hDEAD;
        tick();
        mem_ack_i = 1'b0;
        tests++;
        if ({mem_req_o, wb_valid_o, ready_o, wb_data_o} !== {1'b0, 1'b0, 1'b1, 16'h00A5}) begin
            fails++;
            $display("FAIL store_done got req=%b wb=%b rdy=%b d=%h want 0 0 1 00a5",
                     mem_req_o, wb_valid_o, ready_o, wb_data_o);
        end
        valid_i = 1'b1;
        control_i = 3'd0;
        alu_res_i = 16'h0077;
        tick();
        valid_i = 1'b0;
        tests++;
        if ({wb_valid_o, wb_data_o} !== {1'b1, 16'h0077}) begin
            fails++;
            $display("FAIL store_then_pass got wb=%b d=%h want 1 0077", wb_valid_o, wb_data_o);
        end
        tick();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int guard = 0;
        valid_i = 1'b1;
        control_i = 3'd1;
        alu_res_i = 16'h0009;
        tick();
        valid_i = 1'b0;
        while (mem_req_o && guard < 40) begin
            req_cycles++;
            guard++;
            tick();
        end
        tests++;
        if (req_cycles != 15) begin
            fails++;
            $display("FAIL timeout_req_len got %0d want 15", req_cycles);
        end
        tests++;
        if ({err_o, ready_o, wb_valid_o} !== 3'b110) begin
            fails++;
            $display("FAIL timeout_flags got err=%b rdy=%b wb=%b want 1 1 0",
                     err_o, ready_o, wb_valid_o);
        end
        valid_i = 1'b1;
        control_i = 3'd0;
        alu_res_i = 16'h0042;
        tick();
        valid_i = 1'b0;
        tests++;
        if ({err_o, wb_valid_o, wb_data_o} !== {1'b1, 1'b1, 16'h0042}) begin
            fails++;
            $display("FAIL timeout_sticky got err=%b wb=%b d=%h want 1 1 0042",
                     err_o, wb_valid_o, wb_data_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tests++;
        if (err_o !== 1'b0) begin
            fails++;
            $display("FAIL timeout_err_clear got %b want 0", err_o);
        end
        tick();
    endtask

    task automatic test_ack_at_limit();
        valid_i = 1'b1;
        control_i = 3'd1;
        alu_res_i = 16'h000B;
        tick();
        valid_i = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 15) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 16'hBEEF;
            end
            tests++;
            if (mem_req_o !== 1'b1) begin
                fails++;
                $display("FAIL limit_req_c%0d got %b want 1", c, mem_req_o);
            end
            tick();
        end
        mem_ack_i = 1'b0;
        tests++;
        if ({wb_valid_o, wb_data_o, err_o, mem_req_o, ready_o} !==
            {1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL limit_done got wb=%b d=%h err=%b req=%b rdy=%b want 1 beef 0 0 1",
                     wb_valid_o, wb_data_o, err_o, mem_req_o, ready_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        valid_i = 1'b1;
        control_i = 3'd1;
        alu_res_i = 16'h0021;
        rt_i = 16'h4321;
        tick();
        valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tests++;
        if ({ready_o, mem_req_o, mem_we_o, wb_valid_o, err_o} !== 5'b10000 ||
            {mem_addr_o, mem_wdata_o, wb_data_o} !== 48'h0) begin
            fails++;
            $display("FAIL midrst_state got rdy=%b req=%b we=%b wb=%b err=%b a=%h wd=%h d=%h want all 0 rdy=1",
                     ready_o, mem_req_o, mem_we_o, wb_valid_o, err_o,
                     mem_addr_o, mem_wdata_o, wb_data_o);
        end
        mem_ack_i = 1'b1;
        mem_rdata_i = 16'h5555;
        tick();
        mem_ack_i = 1'b0;
        tests++;
        if ({wb_valid_o, wb_data_o, mem_req_o, ready_o, err_o} !==
            {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL midrst_late_ack got wb=%b d=%h req=%b rdy=%b err=%b want 0 0000 0 1 0",
                     wb_valid_o, wb_data_o, mem_req_o, ready_o, err_o);
        end
        tick();
        tests++;
        if ({wb_valid_o, mem_req_o} !== 2'b00) begin
            fails++;
            $display("FAIL midrst_quiet got wb=%b req=%b want 0 0", wb_valid_o, mem_req_o);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_back_to_back();
        test_load();
        test_store();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
